// File: rtl/wshb_arb_pkg.sv
// Shared types and Wishbone B4 cycle-type constants for the round-robin SDRAM arbiter.
package wshb_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } arb_state_t;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  // A master may only be preempted between transfers, never inside a burst.
  function automatic logic cti_at_boundary(input logic [2:0] cti);
    return (cti == CTI_CLASSIC) || (cti == CTI_EOB);
  endfunction

endpackage

// File: rtl/wshb_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: first request above i_start, wrapping, optionally skipping one index.
module rr_pick #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_start,
  input  logic [IDX_W-1:0] i_excl,
  input  logic             i_excl_en,
  output logic             o_valid,
  output logic [IDX_W-1:0] o_idx
);

  int w_cand;

  // Walk start+1 .. start+N modulo N; the first eligible requester wins.
  always_comb begin
    o_valid = 1'b0;
    o_idx   = '0;
    w_cand  = 0;
    for (int k = 1; k <= N; k++) begin
      w_cand = (int'(i_start) + k) % N;
      if (!o_valid && i_req[w_cand] && !(i_excl_en && (IDX_W'(w_cand) == i_excl))) begin
        o_valid = 1'b1;
        o_idx   = IDX_W'(w_cand);
      end else begin
        o_valid = o_valid;
      end
    end
  end

endmodule

// File: rtl/wshb_arbiter_rr.sv
// N-master to one-slave Wishbone B4 arbiter with round-robin grant and an optional
// burst-safe fairness limit; request mux and response demux follow the registered owner.
module wshb_arbiter_rr
  import wshb_arb_pkg::*;
#(
  parameter  int N_MASTERS = 2,
  parameter  int ADDR_W    = 32,
  parameter  int DATA_W    = 32,
  parameter  int MAX_HOLD  = 0,
  localparam int SEL_W     = DATA_W / 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_MASTERS-1:0]          m_cyc,
  input  logic [N_MASTERS-1:0]          m_stb,
  input  logic [N_MASTERS-1:0]          m_we,
  input  logic [N_MASTERS*ADDR_W-1:0]   m_adr,
  input  logic [N_MASTERS*DATA_W-1:0]   m_dat_ms,
  input  logic [N_MASTERS*SEL_W-1:0]    m_sel,
  input  logic [N_MASTERS*3-1:0]        m_cti,
  input  logic [N_MASTERS*2-1:0]        m_bte,
  output logic [N_MASTERS-1:0]          m_ack,
  output logic [N_MASTERS-1:0]          m_err,
  output logic [N_MASTERS-1:0]          m_rty,
  output logic [N_MASTERS*DATA_W-1:0]   m_dat_sm,
  output logic                          s_cyc,
  output logic                          s_stb,
  output logic                          s_we,
  output logic [ADDR_W-1:0]             s_adr,
  output logic [DATA_W-1:0]             s_dat_ms,
  output logic [SEL_W-1:0]              s_sel,
  output logic [2:0]                    s_cti,
  output logic [1:0]                    s_bte,
  input  logic                          s_ack,
  input  logic                          s_err,
  input  logic                          s_rty,
  input  logic [DATA_W-1:0]             s_dat_sm,
  output logic [N_MASTERS-1:0]          gnt
);

  localparam int IDX_W  = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  localparam int HOLD_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0);
  localparam logic [IDX_W-1:0]  LAST_RST  = IDX_W'(N_MASTERS - 1);

  arb_state_t        r_state;
  logic [IDX_W-1:0]  r_owner;
  logic [IDX_W-1:0]  r_last;
  logic [HOLD_W-1:0] r_hold_cnt;

  arb_state_t        w_state_nxt;
  logic [IDX_W-1:0]  w_owner_nxt;
  logic [IDX_W-1:0]  w_last_nxt;
  logic [HOLD_W-1:0] w_hold_nxt;
  logic              w_grant_chg;
  logic              w_owned;
  logic              w_pick_valid;
  logic [IDX_W-1:0]  w_pick_idx;
  logic              w_preempt;

  assign w_owned = (r_state == OWNED);

  // While owned the owner is excluded, so a valid pick always means a different waiting master.
  rr_pick #(
    .N     (N_MASTERS),
    .IDX_W (IDX_W)
  ) u_pick (
    .i_req     (m_cyc),
    .i_start   (r_last),
    .i_excl    (r_owner),
    .i_excl_en (w_owned),
    .o_valid   (w_pick_valid),
    .o_idx     (w_pick_idx)
  );

  // s_cyc/s_cti already carry the owner's cyc and cti while owned.
  assign w_preempt = (MAX_HOLD > 0) && w_owned && s_cyc && s_ack &&
                     (r_hold_cnt == HOLD_LAST) && cti_at_boundary(s_cti) && w_pick_valid;

  // Grant FSM next state and fairness counter.
  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_last_nxt  = r_last;
    w_grant_chg = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_pick_valid) begin
          w_state_nxt = OWNED;
          w_owner_nxt = w_pick_idx;
          w_last_nxt  = w_pick_idx;
          w_grant_chg = 1'b1;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      OWNED: begin
        if ((!s_cyc && w_pick_valid) || w_preempt) begin
          w_owner_nxt = w_pick_idx;
          w_last_nxt  = w_pick_idx;
          w_grant_chg = 1'b1;
        end else if (!s_cyc) begin
          w_state_nxt = IDLE;
          w_grant_chg = 1'b1;
        end else begin
          w_state_nxt = OWNED;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_grant_chg = 1'b1;
      end
    endcase

    if (w_grant_chg) begin
      w_hold_nxt = '0;
    end else if (w_owned && (s_ack || s_err || s_rty) && (r_hold_cnt != HOLD_MAX)) begin
      w_hold_nxt = r_hold_cnt + HOLD_W'(1);
    end else begin
      w_hold_nxt = r_hold_cnt;
    end
  end

  // Arbitration state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_owner    <= '0;
      r_last     <= LAST_RST;
      r_hold_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_owner    <= w_owner_nxt;
      r_last     <= w_last_nxt;
      r_hold_cnt <= w_hold_nxt;
    end
  end

  // Request mux and response demux; everything not owned reads as zero.
  always_comb begin
    s_cyc    = 1'b0;
    s_stb    = 1'b0;
    s_we     = 1'b0;
    s_adr    = '0;
    s_dat_ms = '0;
    s_sel    = '0;
    s_cti    = 3'b000;
    s_bte    = 2'b00;
    m_ack    = '0;
    m_err    = '0;
    m_rty    = '0;
    m_dat_sm = '0;
    gnt      = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (w_owned && (r_owner == IDX_W'(i))) begin
        gnt[i]                         = 1'b1;
        s_cyc                          = m_cyc[i];
        s_stb                          = m_stb[i];
        s_we                           = m_we[i];
        s_adr                          = m_adr[i*ADDR_W +: ADDR_W];
        s_dat_ms                       = m_dat_ms[i*DATA_W +: DATA_W];
        s_sel                          = m_sel[i*SEL_W +: SEL_W];
        s_cti                          = m_cti[i*3 +: 3];
        s_bte                          = m_bte[i*2 +: 2];
        m_ack[i]                       = s_ack;
        m_err[i]                       = s_err;
        m_rty[i]                       = s_rty;
        m_dat_sm[i*DATA_W +: DATA_W]   = s_dat_sm;
      end else begin
        gnt[i] = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wshb_arbiter_rr.sv
// Directed bench: a 4-master arbiter with MAX_HOLD=4 and a 2-master arbiter with the limit disabled.
module tb_wshb_arbiter_rr;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  logic [3:0]   a_m_cyc, a_m_stb, a_m_we, a_m_ack, a_m_err, a_m_rty, a_gnt;
  logic [127:0] a_m_adr, a_m_dat_ms, a_m_dat_sm;
  logic [15:0]  a_m_sel;
  logic [11:0]  a_m_cti;
  logic [7:0]   a_m_bte;
  logic         a_s_cyc, a_s_stb, a_s_we, a_s_ack, a_s_err, a_s_rty;
  logic [31:0]  a_s_adr, a_s_dat_ms, a_s_dat_sm;
  logic [3:0]   a_s_sel;
  logic [2:0]   a_s_cti;
  logic [1:0]   a_s_bte;

  logic [1:0]   b_m_cyc, b_m_stb, b_m_we, b_m_ack, b_m_err, b_m_rty, b_gnt;
  logic [63:0]  b_m_adr, b_m_dat_ms, b_m_dat_sm;
  logic [7:0]   b_m_sel;
  logic [5:0]   b_m_cti;
  logic [3:0]   b_m_bte;
  logic         b_s_cyc, b_s_stb, b_s_we, b_s_ack, b_s_err, b_s_rty;
  logic [31:0]  b_s_adr, b_s_dat_ms, b_s_dat_sm;
  logic [3:0]   b_s_sel;
  logic [2:0]   b_s_cti;
  logic [1:0]   b_s_bte;

  wshb_arbiter_rr #(.N_MASTERS(4), .ADDR_W(32), .DATA_W(32), .MAX_HOLD(4)) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .m_cyc(a_m_cyc), .m_stb(a_m_stb), .m_we(a_m_we), .m_adr(a_m_adr), .m_dat_ms(a_m_dat_ms),
    .m_sel(a_m_sel), .m_cti(a_m_cti), .m_bte(a_m_bte),
    .m_ack(a_m_ack), .m_err(a_m_err), .m_rty(a_m_rty), .m_dat_sm(a_m_dat_sm),
    .s_cyc(a_s_cyc), .s_stb(a_s_stb), .s_we(a_s_we), .s_adr(a_s_adr), .s_dat_ms(a_s_dat_ms),
    .s_sel(a_s_sel), .s_cti(a_s_cti), .s_bte(a_s_bte),
    .s_ack(a_s_ack), .s_err(a_s_err), .s_rty(a_s_rty), .s_dat_sm(a_s_dat_sm),
    .gnt(a_gnt)
  );

  wshb_arbiter_rr #(.N_MASTERS(2), .ADDR_W(32), .DATA_W(32), .MAX_HOLD(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .m_cyc(b_m_cyc), .m_stb(b_m_stb), .m_we(b_m_we), .m_adr(b_m_adr), .m_dat_ms(b_m_dat_ms),
    .m_sel(b_m_sel), .m_cti(b_m_cti), .m_bte(b_m_bte),
    .m_ack(b_m_ack), .m_err(b_m_err), .m_rty(b_m_rty), .m_dat_sm(b_m_dat_sm),
    .s_cyc(b_s_cyc), .s_stb(b_s_stb), .s_we(b_s_we), .s_adr(b_s_adr), .s_dat_ms(b_s_dat_ms),
    .s_sel(b_s_sel), .s_cti(b_s_cti), .s_bte(b_s_bte),
    .s_ack(b_s_ack), .s_err(b_s_err), .s_rty(b_s_rty), .s_dat_sm(b_s_dat_sm),
    .gnt(b_gnt)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are checked 1ns or more after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    a_m_cyc = '0; a_m_stb = '0; a_m_we = '0; a_m_cti = '0;
    a_s_ack = 1'b0; a_s_err = 1'b0; a_s_rty = 1'b0; a_s_dat_sm = '0;
    b_m_cyc = '0; b_m_stb = '0; b_m_we = '0;
    b_s_ack = 1'b0; b_s_err = 1'b0; b_s_rty = 1'b0; b_s_dat_sm = 32'h5555_AAAA;
    for (int i = 0; i < 4; i++) begin
      a_m_adr[i*32 +: 32]    = 32'hA000_0000 + 32'(i);
      a_m_dat_ms[i*32 +: 32] = 32'hD000_0000 + 32'(i);
      a_m_sel[i*4 +: 4]      = 4'b0001 << i;
      a_m_bte[i*2 +: 2]      = 2'(i);
    end
    for (int i = 0; i < 2; i++) begin
      b_m_adr[i*32 +: 32]    = 32'hB000_0000 + 32'(i);
      b_m_dat_ms[i*32 +: 32] = 32'hE000_0000 + 32'(i);
    end
    b_m_sel = 8'b0011_1111;
    b_m_cti = 6'b111_000;
    b_m_bte = 4'b11_00;

    // Reset held: requests and slave responses must not leak through.
    repeat (2) @(posedge clk);
    #1;
    a_m_cyc = 4'b0001; a_s_ack = 1'b1; a_s_dat_sm = 32'h1234_5678;
    b_m_cyc = 2'b11;   b_s_ack = 1'b1;
    #1;
    chk("rst_a_gnt",   128'(a_gnt), 128'(4'b0000));
    chk("rst_a_scyc",  128'(a_s_cyc), 128'(1'b0));
    chk("rst_a_ack",   128'(a_m_ack), 128'(4'b0000));
    chk("rst_a_dat",   a_m_dat_sm, 128'(0));
    chk("rst_b_gnt",   128'(b_gnt), 128'(2'b00));
    chk("rst_b_scyc",  128'(b_s_cyc), 128'(1'b0));
    chk("rst_b_resp",  128'({b_m_ack, b_m_err, b_m_rty}), 128'(6'b000000));
    chk("rst_b_dat",   128'(b_m_dat_sm), 128'(0));
    step();

    // B: simultaneous requests out of reset, master 0 first, then a bubble-free handover.
    rst_n = 1'b1;
    a_m_cyc = 4'b0000; a_s_ack = 1'b0; a_s_dat_sm = 32'h0;
    b_s_ack = 1'b0; b_m_stb = 2'b11; b_m_we = 2'b01;
    #1;
    chk("b_latency", 128'(b_gnt), 128'(2'b00));
    step();
    chk("b_simul_first", 128'(b_gnt), 128'(2'b01));
    chk("b_scyc_on",     128'(b_s_cyc), 128'(1'b1));
    chk("b_sadr_m0",     128'(b_s_adr), 128'(32'hB000_0000));
    chk("b_swe_m0",      128'(b_s_we), 128'(1'b1));
    b_s_ack = 1'b1;
    #1;
    chk("b_ack_route", 128'(b_m_ack), 128'(2'b01));
    b_s_ack = 1'b0; b_m_cyc = 2'b10;
    #1;
    chk("b_release_scyc", 128'(b_s_cyc), 128'(1'b0));
    step();
    chk("b_handover", 128'(b_gnt), 128'(2'b10));
    chk("b_sadr_m1",  128'(b_s_adr), 128'(32'hB000_0001));
    chk("b_sreq_m1",  128'({b_s_stb, b_s_we, b_s_sel, b_s_cti, b_s_bte}), 128'({1'b1, 1'b0, 4'b0011, 3'b111, 2'b11}));
    chk("b_sdat_m1",  128'(b_s_dat_ms), 128'(32'hE000_0001));

    // B: limit disabled, so an owner at a clean boundary keeps the grant under steady acks.
    b_m_cyc = 2'b11; b_s_ack = 1'b1;
    repeat (6) step();
    chk("b_no_limit",     128'(b_gnt), 128'(2'b10));
    chk("b_no_limit_ack", 128'(b_m_ack), 128'(2'b10));
    b_s_ack = 1'b0; b_m_cyc = 2'b01;
    step();
    chk("b_back_to_0", 128'(b_gnt), 128'(2'b01));
    b_m_cyc = 2'b00;
    step();
    chk("b_idle_gnt",  128'(b_gnt), 128'(2'b00));
    chk("b_idle_scyc", 128'(b_s_cyc), 128'(1'b0));

    // A: single request granted one cycle later.
    a_m_cyc = 4'b0001;
    #1;
    chk("a_latency", 128'(a_gnt), 128'(4'b0000));
    step();
    chk("a_first_grant", 128'(a_gnt), 128'(4'b0001));
    a_m_cyc = 4'b0000;
    step();
    chk("a_idle", 128'(a_gnt), 128'(4'b0000));

    // A: masters 1 and 3 alternate releases, grant order 1,3,1,3.
    a_m_cyc = 4'b1010;
    step();
    chk("a_rr_1", 128'(a_gnt), 128'(4'b0010));
    a_s_ack = 1'b1;
    #1;
    chk("a_rr_ack_1", 128'(a_m_ack), 128'(4'b0010));
    a_s_ack = 1'b0; a_m_cyc = 4'b1000;
    step();
    chk("a_rr_3", 128'(a_gnt), 128'(4'b1000));
    a_m_cyc = 4'b1010; a_s_ack = 1'b1;
    #1;
    chk("a_rr_ack_3", 128'(a_m_ack), 128'(4'b1000));
    a_s_ack = 1'b0; a_m_cyc = 4'b0010;
    step();
    chk("a_rr_1b", 128'(a_gnt), 128'(4'b0010));
    a_m_cyc = 4'b1010; a_s_ack = 1'b1;
    #1;
    chk("a_rr_ack_1b", 128'(a_m_ack), 128'(4'b0010));
    a_s_ack = 1'b0; a_m_cyc = 4'b1000;
    step();
    chk("a_rr_3b", 128'(a_gnt), 128'(4'b1000));
    a_s_ack = 1'b1;
    #1;
    chk("a_rr_ack_3b", 128'(a_m_ack), 128'(4'b1000));
    a_s_ack = 1'b0; a_m_cyc = 4'b0000;
    step();
    chk("a_rr_idle", 128'(a_gnt), 128'(4'b0000));

    // A: classic cycles with master 1 waiting, preempted right after the 4th ack.
    a_m_cyc = 4'b0011;
    step();
    chk("a_hold_grant0", 128'(a_gnt), 128'(4'b0001));
    a_s_ack = 1'b1;
    #1;
    chk("a_hold_ack1", 128'(a_m_ack), 128'(4'b0001));
    repeat (3) step();
    chk("a_hold_after3", 128'(a_gnt), 128'(4'b0001));
    chk("a_hold_ack4",   128'(a_m_ack), 128'(4'b0001));
    step();
    chk("a_preempt",       128'(a_gnt), 128'(4'b0010));
    chk("a_preempt_stall", 128'(a_m_ack), 128'(4'b0010));
    a_s_ack = 1'b0; a_m_cyc = 4'b0000;
    step();
    chk("a_preempt_idle", 128'(a_gnt), 128'(4'b0000));

    // A: 8-beat incrementing burst is never cut; master 1 follows once master 0 lets go.
    a_m_cyc = 4'b0011;
    step();
    chk("a_burst_grant0", 128'(a_gnt), 128'(4'b0001));
    a_s_ack = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      a_m_cti[2:0] = (k == 8) ? 3'b111 : 3'b010;
      #1;
      chk("a_burst_beat", 128'(a_gnt), 128'(4'b0001));
      step();
    end
    a_s_ack = 1'b0; a_m_cyc = 4'b0010; a_m_cti[2:0] = 3'b000;
    step();
    chk("a_burst_next", 128'(a_gnt), 128'(4'b0010));
    a_m_cyc = 4'b0000;
    step();
    chk("a_burst_idle", 128'(a_gnt), 128'(4'b0000));

    // A: owner 2, request mux, err/rty/data routing, then asynchronous reset mid-burst.
    a_m_cyc = 4'b0100; a_m_stb = 4'b0100; a_m_we = 4'b0100; a_m_cti[8:6] = 3'b010;
    step();
    chk("a_owner2",   128'(a_gnt), 128'(4'b0100));
    chk("a_s_ctl2",   128'({a_s_cyc, a_s_stb, a_s_we}), 128'(3'b111));
    chk("a_s_adr2",   128'(a_s_adr), 128'(32'hA000_0002));
    chk("a_s_dat2",   128'(a_s_dat_ms), 128'(32'hD000_0002));
    chk("a_s_attr2",  128'({a_s_sel, a_s_cti, a_s_bte}), 128'({4'b0100, 3'b010, 2'b10}));
    a_s_err = 1'b1; a_s_dat_sm = 32'hDEAD_BEEF;
    #1;
    chk("a_err_route", 128'(a_m_err), 128'(4'b0100));
    chk("a_err_noack", 128'(a_m_ack), 128'(4'b0000));
    chk("a_dat_route", a_m_dat_sm, 128'h0000_0000_DEAD_BEEF_0000_0000_0000_0000);
    a_s_err = 1'b0; a_s_rty = 1'b1;
    #1;
    chk("a_rty_route", 128'(a_m_rty), 128'(4'b0100));
    rst_n = 1'b0;
    #1;
    chk("a_async_scyc", 128'(a_s_cyc), 128'(1'b0));
    chk("a_async_gnt",  128'(a_gnt), 128'(4'b0000));
    chk("a_async_resp", 128'({a_m_rty, a_m_err, a_m_ack}), 128'(12'h000));
    chk("a_async_dat",  a_m_dat_sm, 128'(0));
    step();
    rst_n = 1'b1;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/wshb_arbiter_rr.md
# wshb_arbiter_rr

Parametrised N-master to one-slave Wishbone B4 arbiter, the successor of the two-master VGA/mire SDRAM interconnect. It grants the single SDRAM slave port to one master at a time in round-robin order. An optional fairness limit (MAX_HOLD) can take the grant away from a master that keeps `cyc` asserted, but only at a clean burst boundary. It sits between the display-side masters (VGA reader, mire/pattern writer, future DMA) and the SDRAM controller.

## Interface
- N_MASTERS, 2: number of master ports, 2..8.
- ADDR_W, 32: address width.
- DATA_W, 32: data width, a multiple of 8; SEL_W = DATA_W/8.
- MAX_HOLD, 0: acks a master may receive before it must yield to a waiting master; 0 disables the limit.

Ports:
- clk  in  1  system clock, single domain.
- rst_n  in  1  reset, asynchronous, active-low.
- m_cyc, m_stb, m_we  in  N_MASTERS  per-master cycle, strobe and write enable.
- m_adr  in  N_MASTERS×ADDR_W  per-master address.
- m_dat_ms  in  N_MASTERS×DATA_W  per-master write data.
- m_sel  in  N_MASTERS×SEL_W  per-master byte selects.
- m_cti, m_bte  in  N_MASTERS×3, N_MASTERS×2  per-master cycle type and burst type.
- m_ack, m_err, m_rty  out  N_MASTERS  per-master responses.
- m_dat_sm  out  N_MASTERS×DATA_W  per-master read data.
- s_cyc, s_stb, s_we, s_adr, s_dat_ms, s_sel, s_cti, s_bte  out  as above, one set  slave-side request.
- s_ack, s_err, s_rty, s_dat_sm  in  1, 1, 1, DATA_W  slave responses.
- gnt  out  N_MASTERS  one-hot current grant; all zero in IDLE.

## Operation
- State machine with two states:
  - IDLE: no grant.
  - OWNED: the master in `owner` holds the slave.
- Registered state:
  - `owner`, width clog2(N_MASTERS).
  - `last`, the most recent owner.
  - `hold_cnt`, width clog2(MAX_HOLD+1).
- Round-robin pick: the first index with `m_cyc` high, searching from `last+1` upward and wrapping modulo N_MASTERS.
- IDLE → OWNED: when any `m_cyc` is high. `owner` becomes the pick, `last` becomes the pick, `hold_cnt` clears.
- OWNED, owner's `m_cyc` low, other requests pending: move directly to OWNED with the new pick. There is no idle bubble.
- OWNED, owner's `m_cyc` low, no requests: go to IDLE.
- OWNED, fairness preemption: requires MAX_HOLD>0, owner still has `m_cyc` high, and all of the following in the same cycle:
  - `s_ack` is high;
  - `hold_cnt` equals MAX_HOLD-1;
  - owner's `m_cti` is 3'b000 (classic) or 3'b111 (end of burst);
  - another master's `m_cyc` is high.
  
  The grant then moves to the pick, which excludes the owner this cycle. The preempted master just sees a stalled slave until it is granted again.
- Preemption never happens during an incrementing burst (cti 3'b010).
- `hold_cnt` increments on each `s_ack`, `s_err` or `s_rty` while OWNED. It saturates at MAX_HOLD and clears whenever the grant changes.
- Request mux: in OWNED, all slave-side request outputs follow the owner's inputs. In IDLE, `s_cyc` and `s_stb` are 0 and the remaining request outputs are 0.
- Response demux: the owner receives `s_ack`, `s_err`, `s_rty` and `s_dat_sm`. Every other master sees all-zero responses and all-zero read data.

## Timing
- Reset values:
  - state IDLE, `owner` 0, `last` N_MASTERS-1 (so master 0 wins the first pick), `hold_cnt` 0.
  - outputs: `gnt` 0, `s_cyc` and `s_stb` 0, all `m_ack`, `m_err`, `m_rty` 0, all `m_dat_sm` 0.
- Grant latency: a `m_cyc` rising edge sampled in cycle t makes `s_cyc` high in cycle t+1. The request path is combinational from the registered `owner`.
- Response path is combinational, with zero added latency.
- Release: owner drops `m_cyc` in cycle t; the next owner drives the slave in cycle t+1.
- Simultaneous requests: resolved only by round-robin from `last`.
- Simultaneous events: the owner dropping `cyc` while another master raises it in the same cycle gives a normal handover.
- Reset mid-transfer: all outputs return to their reset values immediately and asynchronously. The transfer is abandoned, and the masters must restart their cycles.

## Structure
- Package `wshb_arb_pkg` contains:
  - `arb_state_t` enum {IDLE, OWNED};
  - CTI constants CTI_CLASSIC=3'b000, CTI_INCR=3'b010, CTI_EOB=3'b111.
- Sub-module `rr_pick`: a combinational round-robin priority encoder. Inputs are the request vector, the start index and an exclude index; outputs are a valid flag and the winning index.

## Test plan
- Reset: hold rst_n low → `gnt`=0, `s_cyc`=0, every `m_ack`=0. Release reset, raise m_cyc[0] → `gnt`=2'b01 one cycle later.
- N=2 simultaneous requests after reset: master 0 is granted. It drops `cyc` → `gnt`=2'b10 on the next cycle with no IDLE cycle between.
- N=4, masters 1 and 3 request continuously, each taking turns releasing → grant order 1,3,1,3. Masters 0 and 2 never see an ack.
- MAX_HOLD=4: master 0 issues classic cycles while holding `cyc`, master 1 waits → master 0 loses the grant right after its 4th ack, and master 1 is granted the next cycle.
- MAX_HOLD=4: master 0 runs an 8-beat incrementing burst (cti 010…111) → no preemption before the end-of-burst ack. Master 1 is granted the cycle after it.
- Error and data routing: slave returns `s_err`=1 and `s_dat_sm`=32'hDEADBEEF to owner 2 → only m_err[2] is high and only m_dat_sm[2] carries the value. Asserting rst_n low mid-burst gives `s_cyc`=0 in the same cycle.
